// File: rtl/dlx_hazard_unit.sv
// dlx_hazard_unit
// ---------------------------------------------------------------------------
// Hazard and forwarding controller for the DLX pipeline. It sits beside the
// decode stage, tracks the destination registers of instructions in flight
// after ID, and produces:
//   - forwarded operands (op_a/op_b) and their source selects for EX,
//   - a one-cycle load-use stall for fetch/decode,
//   - a multi-cycle flush after a taken branch/jump.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   id_valid                ID holds a real instruction
//   id_rs1/id_rs2           source register addresses
//   id_rs1_used/id_rs2_used source is actually read
//   id_rd, id_wr            destination register and write enable
//   id_is_load              ID instruction is a load
//   rf_a, rf_b              register-file read data
//   stage_result            result of entry k at [k*XLEN +: XLEN]
//   ex_branch_taken         branch/jump resolved taken in EX
//   op_a, op_b              forwarded operands to EX
//   fwd_a_sel, fwd_b_sel    0 = register file, k+1 = scoreboard entry k
//   stall                   hold PC and IF/ID, bubble into EX
//   flush                   squash IF/ID contents
//   pipe_busy               any scoreboard entry valid
//   stall_cycles            cycles with stall=1 (saturating)
//   flush_cycles            cycles with flush=1 (saturating)
//
// Optional feature: define DLX_HAZ_PERF_EN to build the two saturating
// performance counters; otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module dlx_hazard_unit #(
  parameter int XLEN         = 32,
  parameter int RBITS        = 5,
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [RBITS-1:0]             id_rs1,
  input  logic [RBITS-1:0]             id_rs2,
  input  logic                         id_rs1_used,
  input  logic                         id_rs2_used,
  input  logic [RBITS-1:0]             id_rd,
  input  logic                         id_wr,
  input  logic                         id_is_load,
  input  logic [XLEN-1:0]              rf_a,
  input  logic [XLEN-1:0]              rf_b,
  input  logic [DEPTH*XLEN-1:0]        stage_result,
  input  logic                         ex_branch_taken,
  output logic [XLEN-1:0]              op_a,
  output logic [XLEN-1:0]              op_b,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b_sel,
  output logic                         stall,
  output logic                         flush,
  output logic                         pipe_busy,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  flush_cycles
);

  localparam int SELW = $clog2(DEPTH+1);

  // Scoreboard: entry 0 = EX, entry DEPTH-1 = WB.
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] load_reg;
  logic [RBITS-1:0] rd_reg [DEPTH];
  logic [3:0]       flush_cnt_reg;

  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;
  logic [SELW-1:0]  sel_a_next;
  logic [SELW-1:0]  sel_b_next;
  logic [XLEN-1:0]  op_a_next;
  logic [XLEN-1:0]  op_b_next;
  logic             flush_raw;
  logic             stall_raw;

  // Only entry 0's load flag can cause a stall; the older flags simply ride
  // along with their entries.
  logic unused_load_flags;
  assign unused_load_flags = |load_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match_a[gi] = valid_reg[gi] && (rd_reg[gi] == id_rs1) &&
                         (id_rs1 != '0) && id_rs1_used;
    assign match_b[gi] = valid_reg[gi] && (rd_reg[gi] == id_rs2) &&
                         (id_rs2 != '0) && id_rs2_used;
  end

  // Scan oldest to youngest so the youngest matching entry is the last
  // assignment and therefore wins.
  always_comb begin
    sel_a_next = '0;
    sel_b_next = '0;
    op_a_next  = rf_a;
    op_b_next  = rf_b;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        sel_a_next = SELW'(k + 1);
        op_a_next  = stage_result[k*XLEN +: XLEN];
      end
      if (match_b[k]) begin
        sel_b_next = SELW'(k + 1);
        op_b_next  = stage_result[k*XLEN +: XLEN];
      end
    end
  end

  assign flush_raw = ex_branch_taken || (flush_cnt_reg != 4'd0);
  // A taken branch squashes the ID instruction anyway, so it masks the stall.
  assign stall_raw = id_valid && !flush_raw && load_reg[0] &&
                     (match_a[0] || match_b[0]);

  // Outputs are forced to their idle values while reset is held.
  assign op_a      = reset ? rf_a : op_a_next;
  assign op_b      = reset ? rf_b : op_b_next;
  assign fwd_a_sel = reset ? '0 : sel_a_next;
  assign fwd_b_sel = reset ? '0 : sel_b_next;
  assign flush     = !reset && flush_raw;
  assign stall     = !reset && stall_raw;
  assign pipe_busy = !reset && (|valid_reg);

  // The shift continues during a stall: older entries drain while a bubble
  // enters entry 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg     <= '0;
      load_reg      <= '0;
      flush_cnt_reg <= 4'd0;
      for (int k = 0; k < DEPTH; k++) rd_reg[k] <= '0;
    end else begin
      valid_reg[0] <= id_valid && id_wr && (id_rd != '0) && !stall_raw && !flush_raw;
      load_reg[0]  <= id_is_load;
      rd_reg[0]    <= id_rd;
      for (int k = 1; k < DEPTH; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        load_reg[k]  <= load_reg[k-1];
        rd_reg[k]    <= rd_reg[k-1];
      end
      // A new taken branch reloads rather than accumulates.
      if (ex_branch_taken)
        flush_cnt_reg <= 4'(FLUSH_CYCLES - 1);
      else if (flush_cnt_reg != 4'd0)
        flush_cnt_reg <= flush_cnt_reg - 4'd1;
    end
  end

`ifdef DLX_HAZ_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_cycles_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_reg <= '0;
      flush_cycles_reg <= '0;
    end else begin
      if (stall_raw && (stall_cycles_reg != 32'hFFFF_FFFF))
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (flush_raw && (flush_cycles_reg != 32'hFFFF_FFFF))
        flush_cycles_reg <= flush_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_cycles = flush_cycles_reg;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_dlx_hazard_unit.sv
// tb_dlx_hazard_unit
// Directed test-plan sequence followed by random traffic, every cycle checked
// against a reference model that keeps the in-flight instructions as a queue
// (youngest first) and the flush window as an absolute "flush until" cycle.
module tb_dlx_hazard_unit;

  localparam int XLEN = 32;
  localparam int RB   = 5;
  localparam int DP   = 3;
  localparam int FC   = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [RB-1:0]   id_rs1, id_rs2, id_rd;
  logic            id_rs1_used, id_rs2_used, id_wr, id_is_load;
  logic [XLEN-1:0] rf_a, rf_b;
  logic [DP*XLEN-1:0] stage_result;
  logic            ex_branch_taken;
  logic [XLEN-1:0] op_a, op_b;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic            stall, flush, pipe_busy;
  logic [31:0]     stall_cycles, flush_cycles;

  dlx_hazard_unit #(.XLEN(XLEN), .RBITS(RB), .DEPTH(DP), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load),
    .rf_a(rf_a), .rf_b(rf_b), .stage_result(stage_result),
    .ex_branch_taken(ex_branch_taken),
    .op_a(op_a), .op_b(op_b), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .flush(flush), .pipe_busy(pipe_busy),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          v;
    logic [RB-1:0] rd;
    logic          ld;
  } ent_t;

  ent_t        q[$];          // q[0] = youngest in-flight instruction
  int          cyc;
  int          flush_until;
  logic [31:0] m_stall_cnt, m_flush_cnt;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < DP; i++) q.push_back(ent_t'{v: 1'b0, rd: '0, ld: 1'b0});
    flush_until = -1;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  task automatic fwd(input logic [RB-1:0] s, input logic u, input logic [31:0] rf,
                     output logic [1:0] sel, output logic [31:0] op);
    sel = 2'd0;
    op  = rf;
    for (int i = 0; i < DP; i++) begin
      if (q[i].v && q[i].rd == s && s != '0 && u) begin
        sel = 2'(i + 1);
        op  = stage_result[i*XLEN +: XLEN];
        break;
      end
    end
  endtask

  task automatic set_id(input logic v, input logic [RB-1:0] r1, input logic u1,
                        input logic [RB-1:0] r2, input logic u2,
                        input logic [RB-1:0] rd, input logic wr, input logic ld);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_wr = wr; id_is_load = ld;
  endtask

  // Check all outputs against the model, take one clock edge, advance the model.
  task automatic step();
    logic [1:0]  e_sa, e_sb;
    logic [31:0] e_oa, e_ob;
    logic        e_fl, e_st, e_busy, hit0;
    #1;
    e_fl = !reset && (ex_branch_taken || cyc <= flush_until);
    fwd(id_rs1, id_rs1_used, rf_a, e_sa, e_oa);
    fwd(id_rs2, id_rs2_used, rf_b, e_sb, e_ob);
    hit0 = q[0].v && ((id_rs1_used && id_rs1 != '0 && q[0].rd == id_rs1) ||
                      (id_rs2_used && id_rs2 != '0 && q[0].rd == id_rs2));
    e_st = !reset && id_valid && !e_fl && q[0].ld && hit0;
    e_busy = 1'b0;
    foreach (q[i]) e_busy = e_busy | q[i].v;
    if (reset) begin
      e_sa = 2'd0; e_sb = 2'd0; e_oa = rf_a; e_ob = rf_b; e_busy = 1'b0;
    end
    chk("op_a", op_a, e_oa);
    chk("op_b", op_b, e_ob);
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e_sa));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e_sb));
    chk("stall", 32'(stall), 32'(e_st));
    chk("flush", 32'(flush), 32'(e_fl));
    chk("pipe_busy", 32'(pipe_busy), 32'(e_busy));
`ifdef DLX_HAZ_PERF_EN
    chk("stall_cycles", stall_cycles, m_stall_cnt);
    chk("flush_cycles", flush_cycles, m_flush_cnt);
`else
    chk("stall_cycles", stall_cycles, 32'd0);
    chk("flush_cycles", flush_cycles, 32'd0);
`endif
    $display("cyc=%0d rst=%0b v=%0b rs1=%0d rs2=%0d rd=%0d br=%0b sel=%0d/%0d stall=%0b flush=%0b busy=%0b",
             cyc, reset, id_valid, id_rs1, id_rs2, id_rd, ex_branch_taken,
             fwd_a_sel, fwd_b_sel, stall, flush, pipe_busy);
    @(posedge clock);
    if (reset) begin
      model_clear();
    end else begin
      if (e_st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (e_fl && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
      if (ex_branch_taken) flush_until = cyc + FC - 1;
      q.push_front(ent_t'{v: id_valid && id_wr && id_rd != '0 && !e_st && !e_fl,
                          rd: id_rd, ld: id_is_load});
      void'(q.pop_back());
    end
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ex_branch_taken = 1'b0;
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    rf_a = 32'hF00D_0001; rf_b = 32'hF00D_0002;
    stage_result = '0;
    cyc = 0;
    model_clear();
    @(posedge clock); #1;
    cyc = 1;
    step();                         // reset state, reset still high
    reset = 1'b0;

    // ADD r3 ; SUB r4,r3,r1
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0); step();
    set_id(1'b1, 3, 1'b1, 1, 1'b1, 4, 1'b1, 1'b0);
    stage_result[0 +: 32] = 32'h0000_0010;
    #1;
    chk("tp_alu_sel", 32'(fwd_a_sel), 32'd1);
    chk("tp_alu_op", op_a, 32'h10);
    chk("tp_alu_stall", 32'(stall), 32'd0);
    step();

    // LW r5 ; ADD r6,r5,r2
    set_id(1'b1, 2, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1); step();
    set_id(1'b1, 5, 1'b1, 2, 1'b1, 6, 1'b1, 1'b0);
    #1 chk("tp_lu_stall1", 32'(stall), 32'd1);
    step();
    stage_result[32 +: 32] = 32'h1234_5678;
    #1;
    chk("tp_lu_stall2", 32'(stall), 32'd0);
    chk("tp_lu_sel", 32'(fwd_a_sel), 32'd2);
    chk("tp_lu_op", op_a, 32'h1234_5678);
    step();

    // r7 in entries 0 and 2: youngest wins
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0); step();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0); step();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0); step();
    set_id(1'b1, 7, 1'b1, 7, 1'b1, 0, 1'b0, 1'b0);
    stage_result[0 +: 32]  = 32'h0000_AAAA;
    stage_result[64 +: 32] = 32'h0000_5555;
    #1;
    chk("tp_young_sel", 32'(fwd_a_sel), 32'd1);
    chk("tp_young_op", op_a, 32'h0000_AAAA);
    chk("tp_young_opb", op_b, 32'h0000_AAAA);
    step();

    // Branch flush: 2 cycles, squashed instructions never enter
    ex_branch_taken = 1'b1;
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b0);
    #1 chk("tp_br_flush1", 32'(flush), 32'd1);
    step();
    ex_branch_taken = 1'b0;
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0);
    #1 chk("tp_br_flush2", 32'(flush), 32'd1);
    step();
    set_id(1'b1, 8, 1'b1, 9, 1'b1, 0, 1'b0, 1'b0);
    #1;
    chk("tp_br_flush3", 32'(flush), 32'd0);
    chk("tp_br_sel_a", 32'(fwd_a_sel), 32'd0);
    chk("tp_br_sel_b", 32'(fwd_b_sel), 32'd0);
    chk("tp_br_busy", 32'(pipe_busy), 32'd0);
    step();

    // Second pulse during flush extends to 3 cycles
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    ex_branch_taken = 1'b1; #1 chk("tp_re_f1", 32'(flush), 32'd1); step();
    ex_branch_taken = 1'b1; #1 chk("tp_re_f2", 32'(flush), 32'd1); step();
    ex_branch_taken = 1'b0; #1 chk("tp_re_f3", 32'(flush), 32'd1); step();
    #1 chk("tp_re_f4", 32'(flush), 32'd0); step();

    // Load-use coinciding with a taken branch
    set_id(1'b1, 2, 1'b1, 0, 1'b0, 10, 1'b1, 1'b1); step();
    set_id(1'b1, 10, 1'b1, 3, 1'b1, 11, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    chk("tp_bl_flush", 32'(flush), 32'd1);
    chk("tp_bl_stall", 32'(stall), 32'd0);
    step();
    ex_branch_taken = 1'b0;
    set_id(1'b1, 11, 1'b1, 10, 1'b1, 0, 1'b0, 1'b0);
    #1;
    chk("tp_bl_bubble", 32'(fwd_a_sel), 32'd0);
    chk("tp_bl_load", 32'(fwd_b_sel), 32'd2);
    step();

    // r0 never forwards
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0); step();
    set_id(1'b1, 0, 1'b1, 0, 1'b1, 12, 1'b0, 1'b0);
    #1;
    chk("tp_r0_sel", 32'(fwd_a_sel), 32'd0);
    chk("tp_r0_op", op_a, 32'hF00D_0001);
    step();

    // Reset with entries in flight and a pending flush
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0); step();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0); step();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0); step();
    ex_branch_taken = 1'b1;
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b0);
    #1 chk("tp_rst_busy_pre", 32'(pipe_busy), 32'd1);
    step();
    ex_branch_taken = 1'b0;
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    #1 chk("tp_rst_flush_during", 32'(flush), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("tp_rst_busy", 32'(pipe_busy), 32'd0);
    chk("tp_rst_flush", 32'(flush), 32'd0);
    chk("tp_rst_scnt", stall_cycles, 32'd0);
    chk("tp_rst_fcnt", flush_cycles, 32'd0);
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset           = ($urandom_range(0, 59) == 0);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      set_id(($urandom_range(0, 3) != 0),
             RB'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             RB'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             RB'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0));
      rf_a = $urandom; rf_b = $urandom;
      for (int k = 0; k < DP; k++) stage_result[k*XLEN +: XLEN] = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
